// File: rtl/brg_pkg.sv
// Shared types and helpers for the MCS-to-FPro bridge: FSM state encoding,
// default error read word and the region-index width helper.
package brg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } brg_state_t;

    localparam logic [31:0] ERR_WORD_DEF = 32'hdead_beef;

    // Region index width; a single region still needs a 1-bit select.
    function automatic int unsigned cs_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/brg_rd_mux.sv
// Combinational N_CS:1 selector of the packed per-region FPro read data.
module brg_rd_mux #(
    parameter int unsigned N_CS  = 2,
    parameter int unsigned SEL_W = 1
) (
    input  logic [32*N_CS-1:0] i_rd_data,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [31:0]        o_rd_data
);

    always_comb begin
        o_rd_data = '0;
        for (int unsigned k = 0; k < N_CS; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_rd_data = i_rd_data[32*k +: 32];
            end
        end
    end

endmodule

// File: rtl/mcs_fpro_bridge_gen.sv
// MicroBlaze MCS IO-bus to FPro bridge with N_CS chip-select regions, read
// latency, per-region stall and error path. BRG_TIMEOUT_EN enables stall abort.
module mcs_fpro_bridge_gen
    import brg_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int unsigned N_CS     = 2,
    parameter int unsigned ADDR_W   = 21,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 io_addr_strobe,
    input  logic                 io_read_strobe,
    input  logic                 io_write_strobe,
    input  logic [3:0]           io_byte_enable,
    input  logic [31:0]          io_address,
    input  logic [31:0]          io_write_data,
    output logic [31:0]          io_read_data,
    output logic                 io_ready,
    output logic [N_CS-1:0]      fp_cs,
    output logic                 fp_wr,
    output logic                 fp_rd,
    output logic [ADDR_W-1:0]    fp_addr,
    output logic [31:0]          fp_wr_data,
    output logic [3:0]           fp_be,
    input  logic [32*N_CS-1:0]   fp_rd_data,
    input  logic [N_CS-1:0]      fp_wait,
    input  logic                 err_clr,
    output logic                 err_sticky
);

    localparam int unsigned CSW      = cs_w(N_CS);
    localparam logic [2:0]  LAT_LOAD = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

    brg_state_t        r_state;
    brg_state_t        w_state_nxt;
    logic [CSW-1:0]    r_sel;
    logic [CSW-1:0]    w_sel;
    logic              r_is_wr;
    logic [2:0]        r_lat;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [31:0]       r_rd_data;
    logic              r_err;
    logic              w_strobe;
    logic              w_hit;
    logic              w_wait;
    logic              w_accept;
    logic              w_capture;
    logic              w_abort;
    logic              w_err_set;
    logic [31:0]       w_mux_data;
    logic              w_unused_addr;

    assign w_strobe      = io_addr_strobe & (io_read_strobe | io_write_strobe);
    assign w_hit         = (io_address[31:24] == BRG_BASE[31:24]);
    assign w_wait        = fp_wait[r_sel];
    assign w_accept      = (r_state == S_IDLE) && w_strobe && w_hit;
    assign w_unused_addr = ^io_address;

    generate
        if (N_CS == 1) begin : g_one_region
            assign w_sel = '0;
        end else begin : g_multi_region
            assign w_sel = io_address[23 -: CSW];
        end
    endgenerate

    brg_rd_mux #(
        .N_CS  (N_CS),
        .SEL_W (CSW)
    ) u_rd_mux (
        .i_rd_data (fp_rd_data),
        .i_sel     (r_sel),
        .o_rd_data (w_mux_data)
    );

`ifdef BRG_TIMEOUT_EN
    logic [7:0] r_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (r_state != S_REQ) begin
            r_stall <= '0;
        end else if (w_wait) begin
            r_stall <= r_stall + 8'd1;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    w_state_nxt = w_hit ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (!w_wait) begin
                    // Zero read latency samples the slave in the REQ exit cycle.
                    if (r_is_wr) begin
                        w_state_nxt = S_DONE;
                    end else if (RD_LAT == 0) begin
                        w_state_nxt = S_DONE;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
`ifdef BRG_TIMEOUT_EN
                else if (r_stall == 8'(TIMEOUT)) begin
                    w_state_nxt = S_DONE;
                    w_abort     = 1'b1;
                end
`endif
            end
            S_WAIT: begin
                if (r_lat == '0) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_err_set = w_abort || (w_strobe && ((r_state != S_IDLE) || !w_hit));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel     <= '0;
            r_is_wr   <= 1'b0;
            r_lat     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel   <= w_sel;
                r_is_wr <= io_write_strobe;
                r_addr  <= io_address[ADDR_W+1:2];
                r_wdata <= io_write_data;
                r_be    <= io_byte_enable;
            end
            // WAIT lasts RD_LAT cycles, so the counter is loaded one short.
            if (r_state == S_REQ) begin
                r_lat <= LAT_LOAD;
            end else if ((r_state == S_WAIT) && (r_lat != '0)) begin
                r_lat <= r_lat - 3'd1;
            end
            if ((r_state == S_IDLE) && w_strobe && !w_hit && !io_write_strobe) begin
                r_rd_data <= '0;
            end else if (w_capture) begin
                r_rd_data <= w_mux_data;
            end else if (w_abort && !r_is_wr) begin
                r_rd_data <= ERR_WORD;
            end
            if (err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        fp_cs = '0;
        for (int unsigned k = 0; k < N_CS; k++) begin
            fp_cs[k] = (r_state == S_REQ) && (r_sel == CSW'(k));
        end
    end

    assign fp_wr        = (r_state == S_REQ) && r_is_wr;
    assign fp_rd        = (r_state == S_REQ) && !r_is_wr;
    assign fp_addr      = r_addr;
    assign fp_wr_data   = r_wdata;
    assign fp_be        = r_be;
    assign io_read_data = r_rd_data;
    assign io_ready     = (r_state == S_DONE);
    assign err_sticky   = r_err;

endmodule

// File: tb/tb_mcs_fpro_bridge_gen.sv
// Scoreboard bench for mcs_fpro_bridge_gen (N_CS=4, ADDR_W=20, RD_LAT=2,
// TIMEOUT=15); timeout expectations follow BRG_TIMEOUT_EN.
module tb_mcs_fpro_bridge_gen;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  cs;
        logic        wr;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int unsigned len;
    } bus_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         io_addr_strobe = 1'b0;
    logic         io_read_strobe = 1'b0;
    logic         io_write_strobe = 1'b0;
    logic [3:0]   io_byte_enable = '0;
    logic [31:0]  io_address = '0;
    logic [31:0]  io_write_data = '0;
    logic [31:0]  io_read_data;
    logic         io_ready;
    logic [3:0]   fp_cs;
    logic         fp_wr;
    logic         fp_rd;
    logic [19:0]  fp_addr;
    logic [31:0]  fp_wr_data;
    logic [3:0]   fp_be;
    logic [127:0] fp_rd_data;
    logic [3:0]   fp_wait = '0;
    logic         err_clr = 1'b0;
    logic         err_sticky;

    assign fp_rd_data = {32'h3c3c_0003, 32'ha5a5_0002, 32'ha5a5_0001, 32'h1111_0000};

    mcs_fpro_bridge_gen #(
        .N_CS    (4),
        .ADDR_W  (20),
        .RD_LAT  (2),
        .TIMEOUT (15)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .fp_cs           (fp_cs),
        .fp_wr           (fp_wr),
        .fp_rd           (fp_rd),
        .fp_addr         (fp_addr),
        .fp_wr_data      (fp_wr_data),
        .fp_be           (fp_be),
        .fp_rd_data      (fp_rd_data),
        .fp_wait         (fp_wait),
        .err_clr         (err_clr),
        .err_sticky      (err_sticky)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_ready = 0;
    rsp_t rq[$];
    bus_t bq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every io_ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        rsp_t r;
        if (io_ready === 1'b1) begin
            n_ready++;
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_unexpected: got io_ready=1 at cycle %0d, expected no pending transaction", cyc);
            end else begin
                r = rq.pop_front();
                chk("ready_cycle", 64'(cyc), 64'(r.cyc));
                chk("read_data", 64'(io_read_data), 64'(r.rdata));
            end
        end
    end

    // Bus monitor: checks each FPro strobe run at its start and its length at its end.
    bus_t        cur;
    logic        prev_on = 1'b0;
    logic        active = 1'b0;
    logic        mon_on;
    int unsigned run = 0;

    always @(negedge clk) begin
        mon_on = fp_wr | fp_rd;
        if (mon_on && !prev_on) begin
            if (bq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_unexpected: got fp_wr=%0b fp_rd=%0b at cycle %0d, expected idle bus", fp_wr, fp_rd, cyc);
            end else begin
                cur = bq.pop_front();
                active = 1'b1;
                run = 0;
                chk("bus_start_cycle", 64'(cyc), 64'(cur.cyc));
                chk("fp_cs", 64'(fp_cs), 64'(cur.cs));
                chk("fp_wr", 64'(fp_wr), 64'(cur.wr));
                chk("fp_rd", 64'(fp_rd), 64'(!cur.wr));
                chk("fp_addr", 64'(fp_addr), 64'(cur.addr));
                chk("fp_wr_data", 64'(fp_wr_data), 64'(cur.wdata));
                chk("fp_be", 64'(fp_be), 64'(cur.be));
            end
        end
        if (mon_on && active) run++;
        if (!mon_on && prev_on && active) begin
            chk("strobe_len", 64'(run), 64'(cur.len));
            active = 1'b0;
        end
        prev_on = mon_on;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = !rd;
        io_address      = a;
        io_write_data   = d;
        io_byte_enable  = be;
        tick(1);
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
    endtask

    task automatic exp_bus(input int unsigned c, input logic [3:0] cs, input logic wr,
                           input logic [19:0] ad, input logic [31:0] wd,
                           input logic [3:0] be, input int unsigned len);
        bus_t b;
        b.cyc = c; b.cs = cs; b.wr = wr; b.addr = ad; b.wdata = wd; b.be = be; b.len = len;
        bq.push_back(b);
    endtask

    task automatic exp_rsp(input int unsigned c, input logic [31:0] d);
        rsp_t r;
        r.cyc = c; r.rdata = d;
        rq.push_back(r);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_cleared", 64'(err_sticky), 64'd0);
    endtask

    initial begin
        int unsigned t0;
        int          nr0;
        logic [31:0] rd_after_to;

        tick(3);
        chk("rst_io_ready", 64'(io_ready), 64'd0);
        chk("rst_io_read_data", 64'(io_read_data), 64'd0);
        chk("rst_fp_cs", 64'(fp_cs), 64'd0);
        chk("rst_fp_wr", 64'(fp_wr), 64'd0);
        chk("rst_fp_rd", 64'(fp_rd), 64'd0);
        chk("rst_err_sticky", 64'(err_sticky), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Write to region 0 while an unselected region stalls.
        t0 = cyc;
        fp_wait = 4'b0010;
        exp_bus(t0 + 1, 4'b0001, 1'b1, 20'h4, 32'h1234_5678, 4'hf, 1);
        exp_rsp(t0 + 2, 32'h0);
        issue(1'b0, 32'hc000_0010, 32'h1234_5678, 4'hf);
        tick(3);
        fp_wait = '0;

        // Read region 2, RD_LAT=2.
        t0 = cyc;
        exp_bus(t0 + 1, 4'b0100, 1'b0, 20'h2, 32'h0, 4'hf, 1);
        exp_rsp(t0 + 4, 32'ha5a5_0002);
        issue(1'b1, 32'hc080_0008, 32'h0, 4'hf);
        tick(5);

        // Partial-byte write to the top word of region 3.
        t0 = cyc;
        exp_bus(t0 + 1, 4'b1000, 1'b1, 20'h3ff, 32'hcafe_f00d, 4'h3, 1);
        exp_rsp(t0 + 2, 32'ha5a5_0002);
        issue(1'b0, 32'hc0c0_0ffc, 32'hcafe_f00d, 4'h3);
        tick(3);
        chk("err_after_hits", 64'(err_sticky), 64'd0);

        // Read region 1 with its fp_wait held for 3 cycles.
        t0 = cyc;
        fp_wait = 4'b0010;
        exp_bus(t0 + 1, 4'b0010, 1'b0, 20'h8, 32'h0, 4'hf, 4);
        exp_rsp(t0 + 7, 32'ha5a5_0001);
        issue(1'b1, 32'hc040_0020, 32'h0, 4'hf);
        tick(3);
        fp_wait = '0;
        tick(5);

        // Read miss: immediate completion with zero data.
        t0 = cyc;
        exp_rsp(t0 + 1, 32'h0);
        issue(1'b1, 32'h8000_0000, 32'h0, 4'hf);
        chk("err_on_miss", 64'(err_sticky), 64'd1);
        tick(2);
        clear_err();

        // Strobe while busy is ignored and flags an error.
        t0 = cyc;
        exp_bus(t0 + 1, 4'b0001, 1'b0, 20'h10, 32'h0, 4'hf, 1);
        exp_rsp(t0 + 4, 32'h1111_0000);
        issue(1'b1, 32'hc000_0040, 32'h0, 4'hf);
        issue(1'b0, 32'hc000_0080, 32'h5555_aaaa, 4'hf);
        chk("err_on_busy", 64'(err_sticky), 64'd1);
        tick(4);
        clear_err();

        // Region 3 stalled well past TIMEOUT.
        t0 = cyc;
        fp_wait = 4'b1000;
`ifdef BRG_TIMEOUT_EN
        rd_after_to = 32'hdead_beef;
        exp_bus(t0 + 1, 4'b1000, 1'b0, 20'h1, 32'h0, 4'hf, 16);
        exp_rsp(t0 + 17, rd_after_to);
        issue(1'b1, 32'hc0c0_0004, 32'h0, 4'hf);
        tick(19);
        fp_wait = '0;
        chk("err_on_timeout", 64'(err_sticky), 64'd1);
        tick(3);
        clear_err();
`else
        rd_after_to = 32'h3c3c_0003;
        exp_bus(t0 + 1, 4'b1000, 1'b0, 20'h1, 32'h0, 4'hf, 31);
        exp_rsp(t0 + 34, rd_after_to);
        issue(1'b1, 32'hc0c0_0004, 32'h0, 4'hf);
        tick(30);
        fp_wait = '0;
        tick(5);
        chk("err_no_timeout", 64'(err_sticky), 64'd0);
`endif

        // err_clr wins over a same-cycle miss; a later miss sets it again.
        t0 = cyc;
        exp_rsp(t0 + 1, rd_after_to);
        err_clr = 1'b1;
        issue(1'b0, 32'h1000_0000, 32'h0, 4'hf);
        err_clr = 1'b0;
        chk("err_clr_priority", 64'(err_sticky), 64'd0);
        tick(2);
        t0 = cyc;
        exp_rsp(t0 + 1, rd_after_to);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hf);
        chk("err_reapplied", 64'(err_sticky), 64'd1);
        tick(2);
        clear_err();

        // Reset asserted while the read sits in WAIT.
        t0 = cyc;
        exp_bus(t0 + 1, 4'b0100, 1'b0, 20'h2, 32'h0, 4'hf, 1);
        issue(1'b1, 32'hc080_0008, 32'h0, 4'hf);
        tick(1);
        reset_n = 1'b0;
        #1;
        chk("rstw_io_read_data", 64'(io_read_data), 64'd0);
        chk("rstw_io_ready", 64'(io_ready), 64'd0);
        chk("rstw_fp_cs", 64'(fp_cs), 64'd0);
        chk("rstw_fp_addr", 64'(fp_addr), 64'd0);
        chk("rstw_fp_be", 64'(fp_be), 64'd0);
        nr0 = n_ready;
        tick(3);
        reset_n = 1'b1;
        tick(6);
        chk("no_ready_after_reset", 64'(n_ready), 64'(nr0));

        // Normal write after reset release.
        t0 = cyc;
        exp_bus(t0 + 1, 4'b0010, 1'b1, 20'h40, 32'hfeed_0001, 4'hc, 1);
        exp_rsp(t0 + 2, 32'h0);
        issue(1'b0, 32'hc040_0100, 32'hfeed_0001, 4'hc);
        tick(4);

        for (int i = 0; i < 50 && (rq.size() != 0 || bq.size() != 0); i++) tick(1);
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
        chk("bus_queue_drained", 64'(bq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got simulation time limit, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
